// File: rtl/issue_stage_multi.sv
// N-wide in-order issue stage: decodes queue heads, issues longest prefix that fits ROB/station credit.
// Packets are registered (1 cycle); backpressure is credit-based via iq_pop; illegal encodings park in TRAP until flush.
module issue_stage_multi #(
  parameter int ISSUE_W = 2,
  parameter int CNT_W   = 4,
  parameter int OPC_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [ISSUE_W-1:0]             iq_valid,
  input  logic [32*ISSUE_W-1:0]          iq_inst,
  input  logic [32*ISSUE_W-1:0]          iq_pc,
  input  logic [32*ISSUE_W-1:0]          iq_pc_next,
  output logic [$clog2(ISSUE_W+1)-1:0]   iq_pop,
  input  logic [CNT_W-1:0]               rob_free,
  input  logic [CNT_W-1:0]               rs_alu_free,
  input  logic [CNT_W-1:0]               rs_br_free,
  input  logic [CNT_W-1:0]               rs_ls_free,
  output logic [ISSUE_W-1:0]             out_valid,
  output logic [2*ISSUE_W-1:0]           out_type,
  output logic [OPC_W*ISSUE_W-1:0]       out_opc,
  output logic [ISSUE_W-1:0]             out_isrd,
  output logic [5*ISSUE_W-1:0]           out_rd,
  output logic [5*ISSUE_W-1:0]           out_sr1,
  output logic [5*ISSUE_W-1:0]           out_sr2,
  output logic [32*ISSUE_W-1:0]          out_imm,
  output logic [9*ISSUE_W-1:0]           out_opr_sel,
  output logic [32*ISSUE_W-1:0]          out_pc,
  output logic [32*ISSUE_W-1:0]          out_pc_next,
  output logic                           trap,
  output logic [31:0]                    trap_pc
);

  localparam logic [1:0] T_ALU = 2'd0, T_BR = 2'd1, T_LS = 2'd2;
  localparam logic [2:0] O_NONE = 3'd0, O_SR = 3'd1, O_PC = 3'd2, O_IIMM = 3'd3,
                         O_SIMM = 3'd4, O_BIMM = 3'd5, O_UIMM = 3'd6, O_JIMM = 3'd7;

  typedef struct packed {
    logic [1:0]       typ;
    logic [OPC_W-1:0] opc;
    logic             isrd;
    logic [4:0]       rd;
    logic [4:0]       sr1;
    logic [4:0]       sr2;
    logic [31:0]      imm;
    logic [8:0]       opr;   // {opr3, opr2, opr1}
  } pkt_t;

  typedef struct packed {
    logic legal;
    pkt_t pkt;
  } dec_t;

  typedef enum logic {S_RUN, S_TRAP} state_t;

  // ALU opcode: 0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and
  function automatic logic [OPC_W-1:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] o;
    case (f3)
      3'd0:    o = alt ? 4'd1 : 4'd0;
      3'd1:    o = 4'd2;
      3'd2:    o = 4'd3;
      3'd3:    o = 4'd4;
      3'd4:    o = 4'd5;
      3'd5:    o = alt ? 4'd7 : 4'd6;
      3'd6:    o = 4'd8;
      default: o = 4'd9;
    endcase
    return OPC_W'(o);
  endfunction

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t        d;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        f7_ok;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    f3    = ins[14:12];
    f7    = ins[31:25];
    f7_ok = (f7 == 7'h00) || (f7 == 7'h20);
    i_imm = {{20{ins[31]}}, ins[31:20]};
    s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    u_imm = {ins[31:12], 12'b0};
    j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    d         = '0;
    d.legal   = 1'b1;
    d.pkt.rd  = ins[11:7];
    d.pkt.sr1 = ins[19:15];
    d.pkt.sr2 = ins[24:20];
    case (ins[6:0])
      7'h13: begin
        d.pkt.typ = T_ALU; d.pkt.isrd = 1'b1; d.pkt.imm = i_imm;
        d.pkt.opr = {O_NONE, O_IIMM, O_SR};
        d.pkt.opc = alu_op(f3, (f3 == 3'd5) && f7[5]);
        if ((f3 == 3'd1 || f3 == 3'd5) && !f7_ok) d.legal = 1'b0;
      end
      7'h33: begin
        d.pkt.typ = T_ALU; d.pkt.isrd = 1'b1;
        d.pkt.opr = {O_NONE, O_SR, O_SR};
        d.pkt.opc = alu_op(f3, f7[5]);
        if (!f7_ok) d.legal = 1'b0;
      end
      7'h37: begin
        d.pkt.typ = T_ALU; d.pkt.isrd = 1'b1; d.pkt.imm = u_imm;
        d.pkt.opr = {O_NONE, O_UIMM, O_NONE};
      end
      7'h17: begin
        d.pkt.typ = T_ALU; d.pkt.isrd = 1'b1; d.pkt.imm = u_imm;
        d.pkt.opr = {O_NONE, O_UIMM, O_PC};
      end
      7'h63: begin
        d.pkt.typ = T_BR; d.pkt.imm = b_imm;
        d.pkt.opr = {O_BIMM, O_SR, O_SR};
        d.pkt.opc = OPC_W'(f3);
        if (f3 == 3'd2 || f3 == 3'd3) d.legal = 1'b0;
      end
      7'h6F: begin
        d.pkt.typ = T_BR; d.pkt.isrd = 1'b1; d.pkt.imm = j_imm;
        d.pkt.opr = {O_NONE, O_JIMM, O_PC};
        d.pkt.opc = OPC_W'(8);
      end
      7'h67: begin
        d.pkt.typ = T_BR; d.pkt.isrd = 1'b1; d.pkt.imm = i_imm;
        d.pkt.opr = {O_NONE, O_IIMM, O_SR};
        d.pkt.opc = OPC_W'(9);
        if (f3 != 3'd0) d.legal = 1'b0;
      end
      7'h03: begin
        d.pkt.typ = T_LS; d.pkt.isrd = 1'b1; d.pkt.imm = i_imm;
        d.pkt.opr = {O_NONE, O_IIMM, O_SR};
        d.pkt.opc = OPC_W'(f3);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) d.legal = 1'b0;
      end
      7'h23: begin
        d.pkt.typ = T_LS; d.pkt.imm = s_imm;
        d.pkt.opr = {O_SIMM, O_SR, O_SR};
        d.pkt.opc = OPC_W'(8 + int'(f3));
        if (f3 > 3'd2) d.legal = 1'b0;
      end
      default: d.legal = 1'b0;
    endcase
    if (d.pkt.rd == 5'd0) d.pkt.isrd = 1'b0;
    return d;
  endfunction

  state_t                 state_q, state_d;
  logic [31:0]            trap_pc_q, trap_pc_d;
  logic [ISSUE_W-1:0]     valid_q, acc;
  pkt_t                   pkt_q   [ISSUE_W];
  logic [31:0]            pc_q    [ISSUE_W];
  logic [31:0]            pcn_q   [ISSUE_W];
  dec_t                   dec     [ISSUE_W];
  logic [CNT_W:0]         eff_rob, eff_alu, eff_br, eff_ls;

  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) dec[k] = decode(iq_inst[32*k +: 32]);
  end

  // Credit already claimed by the packets still sitting in the output register
  always_comb begin
    logic [CNT_W:0] u_rob, u_alu, u_br, u_ls;
    u_rob = '0; u_alu = '0; u_br = '0; u_ls = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (valid_q[k]) begin
        u_rob = u_rob + 1'b1;
        case (pkt_q[k].typ)
          T_BR:    u_br  = u_br + 1'b1;
          T_LS:    u_ls  = u_ls + 1'b1;
          default: u_alu = u_alu + 1'b1;
        endcase
      end
    end
    eff_rob = ({1'b0, rob_free}    > u_rob) ? {1'b0, rob_free}    - u_rob : '0;
    eff_alu = ({1'b0, rs_alu_free} > u_alu) ? {1'b0, rs_alu_free} - u_alu : '0;
    eff_br  = ({1'b0, rs_br_free}  > u_br)  ? {1'b0, rs_br_free}  - u_br  : '0;
    eff_ls  = ({1'b0, rs_ls_free}  > u_ls)  ? {1'b0, rs_ls_free}  - u_ls  : '0;
  end

  always_comb begin
    logic           go, fit, hit;
    logic [CNT_W:0] n_rob, n_alu, n_br, n_ls;
    acc       = '0;
    iq_pop    = '0;
    state_d   = state_q;
    trap_pc_d = trap_pc_q;
    hit       = 1'b0;
    go        = (state_q == S_RUN) && !flush;
    n_rob = '0; n_alu = '0; n_br = '0; n_ls = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      case (dec[k].pkt.typ)
        T_BR:    fit = (n_br  + 1'b1) <= eff_br;
        T_LS:    fit = (n_ls  + 1'b1) <= eff_ls;
        default: fit = (n_alu + 1'b1) <= eff_alu;
      endcase
      fit = fit && ((n_rob + 1'b1) <= eff_rob);
      if (go && iq_valid[k] && dec[k].legal && fit) begin
        acc[k] = 1'b1;
        iq_pop = iq_pop + 1'b1;
        n_rob  = n_rob + 1'b1;
        case (dec[k].pkt.typ)
          T_BR:    n_br  = n_br + 1'b1;
          T_LS:    n_ls  = n_ls + 1'b1;
          default: n_alu = n_alu + 1'b1;
        endcase
      end else begin
        if (go && iq_valid[k] && !dec[k].legal) begin
          hit       = 1'b1;
          trap_pc_d = iq_pc[32*k +: 32];
        end
        go = 1'b0;
      end
    end
    if (flush) begin
      state_d   = S_RUN;
      trap_pc_d = '0;
    end else if (hit) begin
      state_d = S_TRAP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      trap_pc_q <= '0;
      valid_q   <= '0;
      for (int k = 0; k < ISSUE_W; k++) begin
        pkt_q[k] <= '0;
        pc_q[k]  <= '0;
        pcn_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      trap_pc_q <= trap_pc_d;
      valid_q   <= acc;
      for (int k = 0; k < ISSUE_W; k++) begin
        if (acc[k]) begin
          pkt_q[k] <= dec[k].pkt;
          pc_q[k]  <= iq_pc[32*k +: 32];
          pcn_q[k] <= iq_pc_next[32*k +: 32];
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign trap      = (state_q == S_TRAP);
  assign trap_pc   = trap_pc_q;

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_out
    assign out_type[2*g +: 2]        = pkt_q[g].typ;
    assign out_opc[OPC_W*g +: OPC_W] = pkt_q[g].opc;
    assign out_isrd[g]               = pkt_q[g].isrd;
    assign out_rd[5*g +: 5]          = pkt_q[g].rd;
    assign out_sr1[5*g +: 5]         = pkt_q[g].sr1;
    assign out_sr2[5*g +: 5]         = pkt_q[g].sr2;
    assign out_imm[32*g +: 32]       = pkt_q[g].imm;
    assign out_opr_sel[9*g +: 9]     = pkt_q[g].opr;
    assign out_pc[32*g +: 32]        = pc_q[g];
    assign out_pc_next[32*g +: 32]   = pcn_q[g];
  end

endmodule

// File: tb/tb_issue_stage_multi.sv
// Scoreboard bench for issue_stage_multi (ISSUE_W=2): packets expected at issue time are checked one edge later.
module tb_issue_stage_multi;
  localparam int W = 2;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [W-1:0]  iq_valid;
  logic [63:0]   iq_inst, iq_pc, iq_pc_next;
  logic [1:0]    iq_pop;
  logic [3:0]    rob_free, rs_alu_free, rs_br_free, rs_ls_free;
  logic [W-1:0]  out_valid, out_isrd;
  logic [3:0]    out_type;
  logic [7:0]    out_opc;
  logic [9:0]    out_rd, out_sr1, out_sr2;
  logic [63:0]   out_imm, out_pc, out_pc_next;
  logic [17:0]   out_opr_sel;
  logic          trap;
  logic [31:0]   trap_pc;

  issue_stage_multi #(.ISSUE_W(W), .CNT_W(4), .OPC_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_pc_next(iq_pc_next),
    .iq_pop(iq_pop), .rob_free(rob_free), .rs_alu_free(rs_alu_free),
    .rs_br_free(rs_br_free), .rs_ls_free(rs_ls_free),
    .out_valid(out_valid), .out_type(out_type), .out_opc(out_opc), .out_isrd(out_isrd),
    .out_rd(out_rd), .out_sr1(out_sr1), .out_sr2(out_sr2), .out_imm(out_imm),
    .out_opr_sel(out_opr_sel), .out_pc(out_pc), .out_pc_next(out_pc_next),
    .trap(trap), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDI1 = 32'h00500093, LW2 = 32'h0000A103, ADD3 = 32'h002081B3,
                          SUB4  = 32'h40208233, BEQ = 32'h00208063, ILL = 32'h0000007F,
                          NOP   = 32'h00000013, JAL1 = 32'h008000EF, SH = 32'h00209223;

  typedef struct {
    int          slot;
    logic [1:0]  typ;
    logic [3:0]  opc;
    logic        isrd;
    logic [31:0] imm;
    logic [8:0]  opr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_pkt(input int slot, input logic [1:0] typ, input logic [3:0] opc,
                            input logic isrd, input logic [31:0] imm, input logic [8:0] opr,
                            input logic [31:0] pc);
    exp_t e;
    e.slot = slot; e.typ = typ; e.opc = opc; e.isrd = isrd; e.imm = imm; e.opr = opr; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic set_slots(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                           input logic [31:0] p0, input logic [31:0] p1);
    iq_valid   = v;
    iq_inst    = {i1, i0};
    iq_pc      = {p1, p0};
    iq_pc_next = {p1 + 32'd4, p0 + 32'd4};
  endtask

  // Clock one edge, then retire every packet expected from the previous cycle's acceptance.
  task automatic tick(input string name);
    logic [W-1:0] exp_v;
    exp_t         e;
    logic [111:0] got, want;
    @(posedge clk); #1;
    exp_v = '0;
    foreach (sb[i]) exp_v[sb[i].slot] = 1'b1;
    checks++;
    if (out_valid !== exp_v) begin
      errors++;
      $display("FAIL %s out_valid: got %b expected %b", name, out_valid, exp_v);
    end
    while (sb.size() > 0) begin
      e    = sb.pop_front();
      got  = {out_type[2*e.slot +: 2], out_opc[4*e.slot +: 4], out_isrd[e.slot],
              out_imm[32*e.slot +: 32], out_opr_sel[9*e.slot +: 9],
              out_pc[32*e.slot +: 32], out_pc_next[32*e.slot +: 32]};
      want = {e.typ, e.opc, e.isrd, e.imm, e.opr, e.pc, e.pc + 32'd4};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s pkt[%0d] {type,opc,isrd,imm,opr,pc,pcn}: got %h expected %h",
                 name, e.slot, got, want);
      end
    end
  endtask

  task automatic chk_pop(input string name, input logic [1:0] exp);
    #3;
    checks++;
    if (iq_pop !== exp) begin
      errors++;
      $display("FAIL %s iq_pop: got %0d expected %0d", name, iq_pop, exp);
    end
  endtask

  task automatic idle();
    iq_valid = '0;
    tick("idle");
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; iq_valid = '0; iq_inst = '0; iq_pc = '0; iq_pc_next = '0;
    rob_free = 4'd8; rs_alu_free = 4'd8; rs_br_free = 4'd8; rs_ls_free = 4'd8;
    #12;
    checks++;
    if (out_valid !== 2'b00 || trap !== 1'b0 || trap_pc !== 32'd0 || out_imm !== 64'd0) begin
      errors++;
      $display("FAIL reset: got valid=%b trap=%b trap_pc=%h imm=%h expected all zero",
               out_valid, trap, trap_pc, out_imm);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    set_slots(2'b11, ADDI1, LW2, 32'h1000, 32'h1004);
    chk_pop("basic", 2'd2);
    expect_pkt(0, 2'd0, 4'd0, 1'b1, 32'd5, 9'h019, 32'h1000);
    expect_pkt(1, 2'd2, 4'd2, 1'b1, 32'd0, 9'h019, 32'h1004);
    tick("basic");
  endtask

  task automatic test_credit();
    idle();
    rs_alu_free = 4'd1;
    set_slots(2'b11, ADD3, SUB4, 32'h2000, 32'h2004);
    chk_pop("alu_credit1", 2'd1);
    expect_pkt(0, 2'd0, 4'd0, 1'b1, 32'd0, 9'h009, 32'h2000);
    tick("alu_credit1");
    set_slots(2'b11, SUB4, ADD3, 32'h2004, 32'h2008);
    chk_pop("alu_credit_eff0", 2'd0);
    tick("alu_credit_eff0");
    chk_pop("alu_credit_back", 2'd1);
    expect_pkt(0, 2'd0, 4'd1, 1'b1, 32'd0, 9'h009, 32'h2004);
    tick("alu_credit_back");
    rs_alu_free = 4'd8;
    idle();
    rob_free = 4'd1;
    set_slots(2'b11, ADDI1, LW2, 32'h3000, 32'h3004);
    chk_pop("rob_credit1", 2'd1);
    expect_pkt(0, 2'd0, 4'd0, 1'b1, 32'd5, 9'h019, 32'h3000);
    tick("rob_credit1");
    chk_pop("rob_credit_eff0", 2'd0);
    tick("rob_credit_eff0");
    rob_free = 4'd8;
    rs_ls_free = 4'd0;
    set_slots(2'b11, LW2, ADDI1, 32'h3100, 32'h3104);
    chk_pop("ls_block_head", 2'd0);
    tick("ls_block_head");
    set_slots(2'b11, ADDI1, LW2, 32'h3200, 32'h3204);
    chk_pop("ls_block_slot1", 2'd1);
    expect_pkt(0, 2'd0, 4'd0, 1'b1, 32'd5, 9'h019, 32'h3200);
    tick("ls_block_slot1");
    rs_ls_free = 4'd8;
  endtask

  task automatic test_trap();
    idle();
    set_slots(2'b11, BEQ, ILL, 32'h4000, 32'h4004);
    chk_pop("trap_entry", 2'd1);
    expect_pkt(0, 2'd1, 4'd0, 1'b0, 32'd0, 9'h149, 32'h4000);
    tick("trap_entry");
    checks++;
    if (trap !== 1'b1 || trap_pc !== 32'h4004) begin
      errors++;
      $display("FAIL trap_state: got trap=%b pc=%h expected trap=1 pc=00004004", trap, trap_pc);
    end
    set_slots(2'b11, ADDI1, ADDI1, 32'h5000, 32'h5004);
    chk_pop("trap_hold", 2'd0);
    tick("trap_hold");
    flush = 1'b1;
    chk_pop("trap_flush", 2'd0);
    tick("trap_flush");
    flush = 1'b0;
    checks++;
    if (trap !== 1'b0) begin
      errors++;
      $display("FAIL trap_cleared: got %b expected 0", trap);
    end
    chk_pop("trap_resume", 2'd2);
    expect_pkt(0, 2'd0, 4'd0, 1'b1, 32'd5, 9'h019, 32'h5000);
    expect_pkt(1, 2'd0, 4'd0, 1'b1, 32'd5, 9'h019, 32'h5004);
    tick("trap_resume");
  endtask

  task automatic test_isrd_jal();
    set_slots(2'b11, NOP, JAL1, 32'h6000, 32'h6004);
    chk_pop("isrd_jal", 2'd2);
    expect_pkt(0, 2'd0, 4'd0, 1'b0, 32'd0, 9'h019, 32'h6000);
    expect_pkt(1, 2'd1, 4'd8, 1'b1, 32'd8, 9'h03A, 32'h6004);
    tick("isrd_jal");
    set_slots(2'b01, SH, ILL, 32'h6100, 32'h6104);
    chk_pop("store_sh", 2'd1);
    expect_pkt(0, 2'd2, 4'd9, 1'b0, 32'd4, 9'h109, 32'h6100);
    tick("store_sh");
  endtask

  task automatic test_flush();
    set_slots(2'b11, ADDI1, LW2, 32'h7000, 32'h7004);
    flush = 1'b1;
    chk_pop("flush", 2'd0);
    tick("flush");
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    set_slots(2'b11, ADDI1, ILL, 32'h8000, 32'h8004);
    chk_pop("pre_reset", 2'd1);
    expect_pkt(0, 2'd0, 4'd0, 1'b1, 32'd5, 9'h019, 32'h8000);
    tick("pre_reset");
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 2'b00 || trap !== 1'b0 || trap_pc !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b trap=%b trap_pc=%h expected 0/0/0",
               out_valid, trap, trap_pc);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    iq_valid = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_trap();
    test_isrd_jal();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
